i2c_ws2812_ctrl: RTL and testbench

//  I2C write-only slave that receives RGB data for a chain of WS2812-type LEDs and drives their one-wire serial line.

---
 rtl/ledctrl_pkg.sv | 37 +++
 rtl/ws2812_tx.sv | 118 +++++++++++
 rtl/i2c_ws2812_ctrl.sv | 152 +++++++++++++++
 tb/tb_i2c_ws2812_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledctrl_pkg.sv
// ledctrl_pkg -- shared types and constants for the I2C-to-WS2812 controller.
//   i2c_state_t : I2C write-slave FSM states
//   led_state_t : WS2812 serialiser FSM states
//   line_t      : synchronised bus line level plus single-cycle edge strobes
//   ACK / NACK  : SDA drive levels during the ninth SCL clock
//   DEF_*       : default timing in clk cycles (25 MHz clock)
package ledctrl_pkg;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int DEF_T0H_CYC  = 10;
  localparam int DEF_T1H_CYC  = 20;
  localparam int DEF_TBIT_CYC = 31;
  localparam int DEF_TRES_CYC = 1300;

  typedef enum logic [2:0] {
    I2C_IDLE   = 3'd0,
    I2C_ADDR   = 3'd1,
    I2C_CMD    = 3'd2,
    I2C_DATA   = 3'd3,
    I2C_IGNORE = 3'd4
  } i2c_state_t;

  typedef enum logic [1:0] {
    LED_IDLE = 2'd0,
    LED_BIT  = 2'd1,
    LED_RES  = 2'd2
  } led_state_t;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } line_t;

endpackage

// File: rtl/ws2812_tx.sv
// ws2812_tx -- output buffer, bit serialiser and latch gap for a WS2812 chain.
//   clk, reset : system clock, synchronous active-high reset
//   load       : one-cycle strobe, copies load_data into the output buffer and
//                requests a frame (queued as pending while a frame runs)
//   load_data  : 3*LED_CNT bytes, index 0 first on the wire
//   led_o      : serial data, registered
// Build option LEDCTRL_GRB_ORDER_EN: each received R,G,B triple is stored
// (and therefore sent) as G,R,B.
module ws2812_tx
  import ledctrl_pkg::*;
#(
  parameter int LED_CNT  = 3,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int TRES_CYC = DEF_TRES_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [3*LED_CNT-1:0][7:0] load_data,
  output logic                      led_o
);

  localparam int NBYTES = 3*LED_CNT;
  localparam int NBITS  = 8*NBYTES;
  localparam int IW     = $clog2(NBITS);
  localparam int CW     = $clog2(TRES_CYC > TBIT_CYC ? TRES_CYC : TBIT_CYC);

  localparam logic [CW-1:0] T0H       = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H       = CW'(T1H_CYC);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC-1);
  localparam logic [CW-1:0] TRES_LAST = CW'(TRES_CYC-1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(NBITS-1);

  led_state_t              state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           bit_idx, bit_idx_n;
  logic                    pend, pend_n;
  logic [NBYTES-1:0][7:0]  obuf, obuf_n, wire_data;
  logic                    cur_bit, led_n;

  always_comb begin
    wire_data = load_data;
`ifdef LEDCTRL_GRB_ORDER_EN
    for (int l = 0; l < LED_CNT; l++) begin
      wire_data[3*l]   = load_data[3*l+1];
      wire_data[3*l+1] = load_data[3*l];
    end
`endif
  end

  // Everything is computed as next-state so led_o can be a plain flop and the
  // first high phase starts on the very edge that loads the buffer.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    pend_n    = pend;
    obuf_n    = load ? wire_data : obuf;
    case (state)
      LED_IDLE: if (load) begin
        state_n   = LED_BIT;
        cnt_n     = '0;
        bit_idx_n = '0;
      end
      LED_BIT: begin
        if (load) pend_n = 1'b1;
        if (cnt == TBIT_LAST) begin
          cnt_n = '0;
          if (bit_idx == LAST_BIT) state_n = LED_RES;
          else bit_idx_n = bit_idx + IW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LED_RES: begin
        if (load) pend_n = 1'b1;
        if (cnt == TRES_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          if (pend_n) begin
            state_n = LED_BIT;
            pend_n  = 1'b0;
          end else begin
            state_n = LED_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = LED_IDLE;
    endcase
    cur_bit = obuf_n[bit_idx_n[IW-1:3]][3'd7 - bit_idx_n[2:0]];
    led_n   = (state_n == LED_BIT) && (cnt_n < (cur_bit ? T1H : T0H));
  end

  // A load mid-frame replaces the buffer at once; bits not yet sent come from
  // the new data, and the pending frame then resends the whole chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LED_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      pend    <= 1'b0;
      obuf    <= '0;
      led_o   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      pend    <= pend_n;
      obuf    <= obuf_n;
      led_o   <= led_n;
    end
  end

endmodule

// File: rtl/i2c_ws2812_ctrl.sv
// i2c_ws2812_ctrl -- I2C write-only slave feeding a WS2812 LED chain.
//   clk, reset   : system clock, synchronous active-high reset
//   scl_i, sda_i : sampled I2C bus levels (asynchronous to clk)
//   scl_o        : SCL drive, always released (no clock stretching)
//   sda_o        : SDA drive, 0 = ACK, 1 = released
//   led_o        : WS2812 serial data
// Write frame: ADDRESS+W, command byte N (LEDs to update, 0 or >LED_CNT means
// all), then up to 3*N RGB bytes into the shadow buffer. A STOP after at least
// one accepted data byte copies the shadow buffer out and starts a frame.
// Build option LEDCTRL_GRB_ORDER_EN (in ws2812_tx): send each triple as G,R,B.
module i2c_ws2812_ctrl
  import ledctrl_pkg::*;
#(
  parameter logic [6:0] ADDRESS  = 7'h4A,
  parameter int         LED_CNT  = 3,
  parameter int         T0H_CYC  = DEF_T0H_CYC,
  parameter int         T1H_CYC  = DEF_T1H_CYC,
  parameter int         TBIT_CYC = DEF_TBIT_CYC,
  parameter int         TRES_CYC = DEF_TRES_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  output logic scl_o,
  input  logic sda_i,
  output logic sda_o,
  output logic led_o
);

  localparam int NBYTES = 3*LED_CNT;
  localparam int BW     = $clog2(NBYTES+1);

  // [0],[1] are the synchroniser, [2] is the previous synced level for edges.
  // Reset to 1 (idle bus) so leaving reset never fakes an edge.
  logic [2:0] scl_pipe, sda_pipe;
  line_t      scl_ln, sda_ln;
  logic       start_det, stop_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_i};
      sda_pipe <= {sda_pipe[1:0], sda_i};
    end
  end

  assign scl_ln    = '{lvl: scl_pipe[1], rise: scl_pipe[1] & ~scl_pipe[2], fall: ~scl_pipe[1] & scl_pipe[2]};
  assign sda_ln    = '{lvl: sda_pipe[1], rise: sda_pipe[1] & ~sda_pipe[2], fall: ~sda_pipe[1] & sda_pipe[2]};
  assign start_det = scl_ln.lvl & sda_ln.fall;
  assign stop_det  = scl_ln.lvl & sda_ln.rise;

  assign scl_o = 1'b1;

  i2c_state_t             state;
  logic [3:0]             bit_cnt;   // SCL rises seen in this byte, 9 = ACK clock
  logic [7:0]             shreg;
  logic [BW-1:0]          byte_idx, byte_lim;
  logic                   has_data;
  logic                   load;
  logic [NBYTES-1:0][7:0] shadow;
  int                     n_cmd;

  always_comb begin
    n_cmd = int'(shreg);
    if (shreg == 8'd0 || n_cmd > LED_CNT) n_cmd = LED_CNT;
  end

  // Bits shift in on SCL rise. The ACK decision is taken on the SCL fall after
  // bit 8 and held until the fall after bit 9, so SDA only moves while SCL is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= I2C_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      byte_lim <= BW'(NBYTES);
      has_data <= 1'b0;
      load     <= 1'b0;
      shadow   <= '0;
      sda_o    <= 1'b1;
    end else begin
      load <= 1'b0;
      if (stop_det) begin
        state   <= I2C_IDLE;
        bit_cnt <= '0;
        sda_o   <= 1'b1;
        if (has_data) begin
          load     <= 1'b1;
          has_data <= 1'b0;
        end
      end else if (start_det) begin
        state   <= I2C_ADDR;
        bit_cnt <= '0;
        sda_o   <= 1'b1;
      end else if (state == I2C_ADDR || state == I2C_CMD || state == I2C_DATA) begin
        if (scl_ln.rise && bit_cnt != 4'd9) begin
          if (bit_cnt < 4'd8) shreg <= {shreg[6:0], sda_ln.lvl};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (scl_ln.fall && bit_cnt == 4'd9) begin
          sda_o   <= 1'b1;
          bit_cnt <= '0;
        end else if (scl_ln.fall && bit_cnt == 4'd8) begin
          case (state)
            I2C_ADDR: begin
              if (shreg == {ADDRESS, 1'b0}) begin
                sda_o <= ACK;
                state <= I2C_CMD;
              end else begin
                sda_o <= NACK;
                state <= I2C_IGNORE;
              end
            end
            I2C_CMD: begin
              sda_o    <= ACK;
              byte_lim <= BW'(3*n_cmd);
              byte_idx <= '0;
              state    <= I2C_DATA;
            end
            I2C_DATA: begin
              if (byte_idx < byte_lim) begin
                shadow[byte_idx] <= shreg;
                byte_idx         <= byte_idx + BW'(1);
                has_data         <= 1'b1;
                sda_o            <= ACK;
              end else begin
                sda_o <= NACK;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  ws2812_tx #(
    .LED_CNT  (LED_CNT),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC),
    .TRES_CYC (TRES_CYC)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (shadow),
    .led_o     (led_o)
  );

endmodule

// File: tb/tb_i2c_ws2812_ctrl.sv
// Bench for i2c_ws2812_ctrl: I2C master tasks drive an open-drain bus model,
// a monitor turns led_o into high/low run lengths, and frames are decoded back
// into bytes and compared against hand-computed buffer contents.
module tb_i2c_ws2812_ctrl;

  logic clk = 1'b0, reset = 1'b1;
  logic scl_drv = 1'b1, sda_drv = 1'b1;
  logic scl_o, sda_o, led_o;
  logic scl_bus, sda_bus;

  assign scl_bus = scl_drv & scl_o;
  assign sda_bus = sda_drv & sda_o;

  i2c_ws2812_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .scl_i (scl_bus),
    .scl_o (scl_o),
    .sda_i (sda_bus),
    .sda_o (sda_o),
    .led_o (led_o)
  );

  always #20 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int qtr = 55;              // quarter SCL period in clk cycles
  longint cyc = 0;
  int hi_q[$], lo_q[$];
  longint rise_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // led_o run-length monitor
  initial begin
    logic led_q;
    int hi_len, lo_len;
    led_q = 1'b0; hi_len = 0; lo_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (led_o === 1'b1) begin
        if (!led_q) begin
          lo_q.push_back(lo_len);
          rise_cyc.push_back(cyc);
          hi_len = 0;
        end
        hi_len++;
        led_q = 1'b1;
      end else begin
        if (led_q) begin
          hi_q.push_back(hi_len);
          lo_len = 0;
        end
        lo_len++;
        led_q = 1'b0;
      end
    end
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    hi_q.delete(); lo_q.delete(); rise_cyc.delete();
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; scl_drv = 1'b1; wait_clk(qtr);
    sda_drv = 1'b0; wait_clk(qtr);
    scl_drv = 1'b0; wait_clk(qtr);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; wait_clk(qtr);
      scl_drv = 1'b1; wait_clk(2*qtr);
      scl_drv = 1'b0; wait_clk(qtr);
    end
    sda_drv = 1'b1; wait_clk(qtr);
    scl_drv = 1'b1; wait_clk(qtr);
    acked = ~sda_o;
    wait_clk(qtr);
    scl_drv = 1'b0; wait_clk(qtr);
  endtask

  task automatic i2c_stop(output longint t);
    sda_drv = 1'b0; wait_clk(qtr);
    scl_drv = 1'b1; wait_clk(qtr);
    sda_drv = 1'b1; t = cyc;
    wait_clk(qtr);
  endtask

  // Full write: address+W, command, data bytes (MSB-first packed), STOP.
  task automatic i2c_write(input logic [7:0] cmd, input int nd, input logic [71:0] d,
                           output int nacks, output longint t);
    logic a;
    nacks = 0;
    i2c_start();
    i2c_byte(8'h94, a); if (!a) nacks++;
    i2c_byte(cmd, a);   if (!a) nacks++;
    for (int i = 0; i < nd; i++) begin
      i2c_byte(d[71-8*i -: 8], a);
      if (!a) nacks++;
    end
    i2c_stop(t);
  endtask

  function automatic logic [71:0] wire_order(input logic [71:0] x);
    logic [71:0] y;
    y = x;
`ifdef LEDCTRL_GRB_ORDER_EN
    for (int l = 0; l < 3; l++) begin
      y[71-24*l -: 8] = x[63-24*l -: 8];
      y[63-24*l -: 8] = x[71-24*l -: 8];
    end
`endif
    return y;
  endfunction

  task automatic chk_frame(input string name, input int base, input logic [71:0] exp);
    logic [7:0] b;
    logic ok;
    int k;
    for (int i = 0; i < 9; i++) begin
      ok = 1'b1; b = '0;
      for (int j = 0; j < 8; j++) begin
        k = base + 8*i + j;
        if (k >= hi_q.size()) ok = 1'b0;
        else if (hi_q[k] == 20) b[7-j] = 1'b1;
        else if (hi_q[k] != 10) ok = 1'b0;
      end
      chk($sformatf("%s byte%0d", name, i), ok ? {24'd0, b} : 32'hBAD, {24'd0, exp[71-8*i -: 8]});
    end
  endtask

  task automatic chk_periods(input string name, input int base);
    int bad;
    bad = 0;
    for (int k = 1; k < 72; k++)
      if (base + k >= lo_q.size() || lo_q[base+k] != 31 - hi_q[base+k-1]) bad++;
    chk({name, " bit_period_errs"}, bad, 0);
  endtask

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] bytes;   // byte 0 in the MSBs
    logic [11:0] ack;     // bit 11 = byte 0
    logic        frame;
    logic [71:0] f;       // expected buffer, received order
  } vec_t;

  vec_t vt [4];

  task automatic set_vec(input int i, input string name, input int nb, input logic [95:0] bytes,
                         input logic [11:0] ack, input logic frame, input logic [71:0] f);
    vt[i].name = name; vt[i].nb = nb; vt[i].bytes = bytes;
    vt[i].ack = ack; vt[i].frame = frame; vt[i].f = f;
  endtask

  initial begin
    longint t_stop;
    logic acked;
    int nacks, budget;
    logic [71:0] p_dat, exp2;

    set_vec(0, "main", 11, {8'h94, 8'h03, 72'hAB3684D0255A00770D, 8'h00}, 12'hFFE, 1'b1,
            72'hAB3684D0255A00770D);
    set_vec(1, "bad_addr", 3, {8'h96, 8'h03, 8'h11, 72'h0}, 12'h000, 1'b0, 72'h0);
    set_vec(2, "read_bit", 3, {8'h95, 8'h03, 8'h22, 72'h0}, 12'h000, 1'b0, 72'h0);
    set_vec(3, "short_cmd", 6, {8'h94, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 48'h0}, 12'hF80, 1'b1,
            72'h112233D0255A00770D);

    wait_clk(3);
    chk("reset sda_o", sda_o, 1'b1);
    chk("reset scl_o", scl_o, 1'b1);
    chk("reset led_o", led_o, 1'b0);
    reset = 1'b0;
    wait_clk(5);

    for (int v = 0; v < 4; v++) begin
      clear_mon();
      qtr = 55;
      i2c_start();
      for (int i = 0; i < vt[v].nb; i++) begin
        i2c_byte(vt[v].bytes[95-8*i -: 8], acked);
        chk($sformatf("%s ack%0d", vt[v].name, i), acked, vt[v].ack[11-i]);
      end
      i2c_stop(t_stop);
      if (vt[v].frame) begin
        wait_clk(72*31 + 1300 + 40);
        chk({vt[v].name, " bits"}, hi_q.size(), 72);
        chk({vt[v].name, " first_rise_latency_ok"},
            (rise_cyc.size() > 0 && rise_cyc[0] - t_stop >= 1 && rise_cyc[0] - t_stop <= 8), 1'b1);
        chk_frame(vt[v].name, 0, wire_order(vt[v].f));
        chk_periods(vt[v].name, 0);
        if (v == 0) begin
          chk("main first_hi", hi_q.size() > 0 ? hi_q[0] : -1, 20);
          chk("main first_lo", lo_q.size() > 1 ? lo_q[1] : -1, 11);
        end
      end else begin
        wait_clk(200);
        chk({vt[v].name, " no_frame"}, rise_cyc.size(), 0);
      end
    end

    // Two writes back to back on a faster bus, so the second STOP lands while
    // the first frame is still shifting bits (around byte 7). Bytes 0..2 of the
    // first frame are already out when the buffer is replaced.
    clear_mon();
    qtr = 10;
    p_dat = 72'h0FF0A53CC35A817EE7;
    i2c_write(8'h03, 9, p_dat, nacks, t_stop);
    chk("dbl first nacks", nacks, 0);
    i2c_write(8'h01, 3, {24'h966918, 48'h0}, nacks, t_stop);
    chk("dbl second nacks", nacks, 0);
    budget = 0;
    while (hi_q.size() < 144 && budget < 8000) begin
      wait_clk(1);
      budget++;
    end
    wait_clk(1400);
    chk("dbl bits", hi_q.size(), 144);
    chk_frame("dbl f1", 0, wire_order(p_dat));
    exp2 = {24'h966918, p_dat[47:0]};
    chk_frame("dbl f2", 72, wire_order(exp2));
    chk("dbl gap", lo_q.size() > 72 && hi_q.size() > 71 ? lo_q[72] : -1,
        hi_q.size() > 71 ? 31 - hi_q[71] + 1300 : 0);
    chk_periods("dbl f2", 72);

    // Reset during a high phase of a running frame.
    clear_mon();
    i2c_write(8'h03, 9, p_dat, nacks, t_stop);
    wait_clk(300);
    budget = 0;
    while (led_o !== 1'b1 && budget < 40) begin
      wait_clk(1);
      budget++;
    end
    chk("rst led_high_before", led_o, 1'b1);
    reset = 1'b1;
    wait_clk(1);
    chk("rst led_o", led_o, 1'b0);
    chk("rst sda_o", sda_o, 1'b1);
    wait_clk(2);
    reset = 1'b0;
    clear_mon();
    wait_clk(3600);
    chk("rst no_output", rise_cyc.size(), 0);
    i2c_write(8'h01, 3, {24'hC0FFEE, 48'h0}, nacks, t_stop);
    chk("rst write nacks", nacks, 0);
    wait_clk(72*31 + 1300 + 40);
    chk("rst bits", hi_q.size(), 72);
    chk_frame("rst frame", 0, wire_order({24'hC0FFEE, 48'h0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
